// File: rtl/issue_stage_if.sv
// ----------------------------------------------------------------------------
// issue_stage_if
//
// Bus interfaces around the issue stage.
//
// decode_issue_if : decode -> issue stage instruction handshake.
//   in_valid        decode presents an instruction
//   in_ready        issue FIFO can accept
//   in_func_select  target functional unit
//   in_dest_reg     destination register
//   in_rob_entry    ROB tag
//   in_payload      opaque operand/immediate/op-field bundle
//   modport master  = decode side, modport slave = issue stage side
//
// issue_exec_if : issue stage -> execute stage issue bundle.
//   alu_free        per-unit free flags from execute
//   func_select     issued unit, or the dummy NOP unit
//   latency_counter latency of the issued unit
//   rob_entry       ROB tag of the issued instruction
//   dest_reg        destination register of the issued instruction
//   payload         opaque payload of the issued instruction
//   ins_nop         high when nothing issues this cycle
//   modport master  = issue stage side, modport slave = execute side
// ----------------------------------------------------------------------------
interface decode_issue_if #(
    parameter int ROB_SIZE      = 4,
    parameter int DEST_REG_SIZE = 3,
    parameter int PAYLOAD_WIDTH = 160
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_func_select;
    logic [DEST_REG_SIZE-1:0] in_dest_reg;
    logic [ROB_SIZE-1:0]      in_rob_entry;
    logic [PAYLOAD_WIDTH-1:0] in_payload;

    modport master (
        output in_valid, in_func_select, in_dest_reg, in_rob_entry, in_payload,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_func_select, in_dest_reg, in_rob_entry, in_payload,
        output in_ready
    );
endinterface

interface issue_exec_if #(
    parameter int NUM_ALU       = 5,
    parameter int ROB_SIZE      = 4,
    parameter int DEST_REG_SIZE = 3,
    parameter int PAYLOAD_WIDTH = 160
);
    logic [NUM_ALU-1:0]       alu_free;
    logic [2:0]               func_select;
    logic [4:0]               latency_counter;
    logic [ROB_SIZE-1:0]      rob_entry;
    logic [DEST_REG_SIZE-1:0] dest_reg;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     ins_nop;

    modport master (
        input  alu_free,
        output func_select, latency_counter, rob_entry, dest_reg, payload, ins_nop
    );

    modport slave (
        output alu_free,
        input  func_select, latency_counter, rob_entry, dest_reg, payload, ins_nop
    );
endinterface

// File: rtl/issue_stage.sv
// ----------------------------------------------------------------------------
// issue_stage
//
// In-order issue buffer between decode and execute. Decoded instructions are
// queued in a small circular FIFO; the head is released to its functional
// unit only when that unit is free and not blocked, producing one registered
// issue bundle per cycle (or a NOP bundle when nothing issues). Heads that
// name a non-existent unit are dropped and counted.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   i_flush        discard all queued and in-flight issue state
//   dec            decode_issue_if.slave  (instruction handshake in)
//   exe            issue_exec_if.master   (issue bundle out, alu_free in)
//   o_occupancy    current FIFO count
//   o_bad_fu_count saturating count of dropped illegal entries
// ----------------------------------------------------------------------------
module issue_stage #(
    parameter int         DEPTH         = 4,
    parameter int         NUM_ALU       = 5,
    parameter logic [2:0] DUMMY_ALU     = 3'b101,
    parameter int         ROB_SIZE      = 4,
    parameter int         DEST_REG_SIZE = 3,
    parameter int         PAYLOAD_WIDTH = 160,
    parameter int         LAT0          = 1,
    parameter int         LAT1          = 4,
    parameter int         LAT2          = 3,
    parameter int         LAT3          = 1,
    parameter int         LAT4          = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    decode_issue_if.slave            dec,
    issue_exec_if.master             exe,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic [7:0]               o_bad_fu_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    // Multi-cycle units whose alu_free lags one cycle behind an issue.
    localparam logic [NUM_ALU-1:0] BLOCKING_UNITS = NUM_ALU'(5'b10110);

    logic [2:0]               r_fifo_func [DEPTH];
    logic [DEST_REG_SIZE-1:0] r_fifo_dest [DEPTH];
    logic [ROB_SIZE-1:0]      r_fifo_rob  [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] r_fifo_pay  [DEPTH];

    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic [NUM_ALU-1:0]       r_block;
    logic [7:0]               r_bad_fu_count;

    logic [2:0]               r_func_select;
    logic [4:0]               r_latency;
    logic [ROB_SIZE-1:0]      r_rob_entry;
    logic [DEST_REG_SIZE-1:0] r_dest_reg;
    logic [PAYLOAD_WIDTH-1:0] r_payload;
    logic                     r_ins_nop;

    logic                     w_in_ready;
    logic                     w_push;
    logic                     w_not_empty;
    logic [2:0]               w_head_func;
    logic                     w_fu_legal;
    logic                     w_unit_free;
    logic                     w_issue;
    logic                     w_drop;
    logic                     w_pop;
    logic [4:0]               w_latency;
    logic [NUM_ALU-1:0]       w_block_next;

    // in_ready never looks at alu_free, so a full FIFO refuses pushes even
    // in a cycle that also pops.
    assign w_in_ready  = (r_count < FULL_COUNT) && !reset;
    assign w_push      = dec.in_valid && w_in_ready && !i_flush;
    assign w_not_empty = (r_count != '0);
    assign w_head_func = r_fifo_func[r_rd_ptr];
    assign w_fu_legal  = (w_head_func < 3'(NUM_ALU));
    assign w_issue     = w_not_empty && w_fu_legal && w_unit_free;
    assign w_drop      = w_not_empty && !w_fu_legal;
    assign w_pop       = w_issue || w_drop;

    always_comb begin
        w_unit_free  = 1'b0;
        w_block_next = '0;
        w_latency    = 5'd0;
        if (w_fu_legal) begin
            w_unit_free = exe.alu_free[w_head_func] && !r_block[w_head_func];
        end
        if (w_issue) begin
            w_block_next[w_head_func] = BLOCKING_UNITS[w_head_func];
        end
        case (w_head_func)
            3'd0:    w_latency = 5'(LAT0);
            3'd1:    w_latency = 5'(LAT1);
            3'd2:    w_latency = 5'(LAT2);
            3'd3:    w_latency = 5'(LAT3);
            3'd4:    w_latency = 5'(LAT4);
            default: w_latency = 5'd0;
        endcase
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_func[r_wr_ptr] <= dec.in_func_select;
            r_fifo_dest[r_wr_ptr] <= dec.in_dest_reg;
            r_fifo_rob[r_wr_ptr]  <= dec.in_rob_entry;
            r_fifo_pay[r_wr_ptr]  <= dec.in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_block        <= '0;
            r_bad_fu_count <= 8'd0;
            r_func_select  <= DUMMY_ALU;
            r_latency      <= 5'd0;
            r_rob_entry    <= '0;
            r_dest_reg     <= '0;
            r_payload      <= '0;
            r_ins_nop      <= 1'b1;
        end else if (i_flush) begin
            // bad_fu_count deliberately survives a flush.
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_block       <= '0;
            r_func_select <= DUMMY_ALU;
            r_latency     <= 5'd0;
            r_rob_entry   <= '0;
            r_dest_reg    <= '0;
            r_payload     <= '0;
            r_ins_nop     <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_block <= w_block_next;
            if (w_drop && (r_bad_fu_count != 8'hFF)) begin
                r_bad_fu_count <= r_bad_fu_count + 8'd1;
            end
            if (w_issue) begin
                r_func_select <= w_head_func;
                r_latency     <= w_latency;
                r_rob_entry   <= r_fifo_rob[r_rd_ptr];
                r_dest_reg    <= r_fifo_dest[r_rd_ptr];
                r_payload     <= r_fifo_pay[r_rd_ptr];
                r_ins_nop     <= 1'b0;
            end else begin
                r_func_select <= DUMMY_ALU;
                r_latency     <= 5'd0;
                r_rob_entry   <= '0;
                r_dest_reg    <= '0;
                r_payload     <= '0;
                r_ins_nop     <= 1'b1;
            end
        end
    end

    assign dec.in_ready        = w_in_ready;
    assign exe.func_select     = r_func_select;
    assign exe.latency_counter = r_latency;
    assign exe.rob_entry       = r_rob_entry;
    assign exe.dest_reg        = r_dest_reg;
    assign exe.payload         = r_payload;
    assign exe.ins_nop         = r_ins_nop;
    assign o_occupancy         = r_count;
    assign o_bad_fu_count      = r_bad_fu_count;
endmodule

// File: doc/issue_stage.md
# issue_stage

In-order issue buffer between decode and the execute stage. It queues decoded instructions in a small FIFO and releases the head to its target functional unit only when that unit reports free. Each issue cycle it presents one registered issue bundle, or a NOP bundle when nothing issues. It is the producer side of the execute stage's `func_select` / `latency_counter` / `alu_free` interface.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two).
- `NUM_ALU`, 5: real functional units, indices 0..4.
- `DUMMY_ALU`, 3'b101: `func_select` value for a NOP.
- `ROB_SIZE`, 4: ROB tag width.
- `DEST_REG_SIZE`, 3: destination register width.
- `PAYLOAD_WIDTH`, 160: opaque operand/immediate/op-field bundle. This block does not interpret it.
- `LAT0`..`LAT4`, 1/4/3/1/1: latency loaded into `latency_counter` for units 0..4.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discard all queued and in-flight issue state.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  FIFO can accept.
- `in_func_select`  in  3  target unit.
- `in_dest_reg`  in  DEST_REG_SIZE.
- `in_rob_entry`  in  ROB_SIZE.
- `in_payload`  in  PAYLOAD_WIDTH.
- `alu_free`  in  NUM_ALU  per-unit free flags from the execute stage.
- `func_select`  out  3  issued unit, or DUMMY_ALU.
- `latency_counter`  out  5  latency of the issued unit.
- `rob_entry`  out  ROB_SIZE.
- `dest_reg`  out  DEST_REG_SIZE.
- `payload`  out  PAYLOAD_WIDTH.
- `ins_nop`  out  1  high when no instruction is issued this cycle.
- `occupancy`  out  clog2(DEPTH)+1  current FIFO count.
- `bad_fu_count`  out  8  saturating count of dropped illegal entries.

## Operation
- **FIFO.** Circular buffer with read and write pointers and a count.
  - Push when `in_valid && in_ready`.
  - `in_ready` = (count < DEPTH) && !reset. It is not combinationally dependent on `alu_free`.
  - Pointers wrap modulo DEPTH.
- **Head evaluation (combinational), with f = head `func_select`:**
  - f > 4: illegal. Pop the entry, issue a NOP, and increment `bad_fu_count` (saturate at 255).
  - f ≤ 4, and `alu_free[f]` && !`block[f]`: issue. Pop the entry and register the bundle with `latency_counter` = LATf.
  - Otherwise: stall. No pop; issue a NOP.
- **Block mask.** `block` is a NUM_ALU-bit register.
  - On an issue to unit 1, 2 or 4, set `block[f]` for exactly the next cycle. This covers the one-cycle lag before the execute stage deasserts `alu_free`.
  - Units 0 and 3 are never blocked, so back-to-back issue to them is allowed.
  - All other bits clear each cycle.
- **NOP bundle:** `func_select`=DUMMY_ALU, `ins_nop`=1, `latency_counter`=0, `rob_entry`=0, `dest_reg`=0, `payload`=0.
- **Simultaneous push and pop.** Allowed in the same cycle whenever `in_ready` is high; count is unchanged. An entry pushed this cycle into an empty FIFO is not visible to head evaluation until the next cycle.
- **Flush.**
  - Clears count, both pointers and `block`.
  - Forces the next output to the NOP bundle.
  - Any push in the same cycle is discarded.
  - `bad_fu_count` is preserved.

## Timing
- **Reset values:**
  - All outputs take the NOP bundle values.
  - `occupancy`=0 and `bad_fu_count`=0.
  - `in_ready`=0 while `reset` is high, and 1 in the first cycle after.
- **Latency.** Minimum 2 cycles from push to issue: the push is registered at edge N, head evaluation happens in cycle N, and the bundle is visible after edge N+1.
- **Registered outputs.** All issue outputs are registered and change only on `clk`. `alu_free` is sampled in the cycle before the bundle appears.
- **Throughput.** At most one issue per cycle.
- **Priority:** `reset` > `flush` > normal operation.
- **Empty FIFO.** Emits the NOP bundle every cycle; `block` still decays.
- **Full FIFO.** `in_ready`=0 even if a pop occurs that cycle.
- **Reset mid-operation.** Queued entries are lost; no partial bundle is emitted.

## Test plan
- **Basic issue.** Reset, then push {f=0, rob=3, dest=5} with all `alu_free`=1. Bundle appears 2 cycles after the push: `func_select`=0, `latency_counter`=1, `rob_entry`=3, `ins_nop`=0. The cycle after shows NOP.
- **Stall on busy unit.** Push f=1 while `alu_free[1]`=0 for 5 cycles, then 1. Output is NOP while busy; issue appears the cycle after `alu_free[1]` rises, with latency 4. `occupancy` holds 1 throughout the stall.
- **Block mask.** Push two f=2 entries back-to-back with `alu_free[2]` held at 1. Issues appear separated by one NOP cycle. Repeat with f=0: issues appear on consecutive cycles.
- **Full and wrap.** Hold `alu_free`=0 and push 4 entries: `in_ready` drops after the 4th. Release the units and push 6 more, checking pointer wrap. All 10 issue in FIFO order with matching `rob_entry` values.
- **Illegal unit.** Push f=6 followed by f=3. The f=6 entry produces a NOP and `bad_fu_count`=1; the f=3 entry issues on the next cycle.
- **Flush.** Fill 3 entries, then assert `flush` together with `in_valid`. The next cycle shows `occupancy`=0 and NOP output. The flushed pushes never issue, and `bad_fu_count` is unchanged.
